// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants and receiver FSM encoding.
// Used by both the timing generator and the timing receiver.
package vga_timing_pkg;

    localparam int unsigned VGA_H_SYNC  = 96;
    localparam int unsigned VGA_H_BP    = 48;
    localparam int unsigned VGA_H_VIS   = 640;
    localparam int unsigned VGA_H_FP    = 16;
    localparam int unsigned VGA_H_FRAME = 800;

    localparam int unsigned VGA_V_SYNC  = 2;
    localparam int unsigned VGA_V_BP    = 33;
    localparam int unsigned VGA_V_VIS   = 480;
    localparam int unsigned VGA_V_FP    = 10;
    localparam int unsigned VGA_V_FRAME = 525;

    localparam int unsigned VGA_LOCK_FRAMES = 2;
    localparam int unsigned VGA_CNT_W       = 16;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } rx_state_e;

endpackage

// File: rtl/vga_sync_sampler.sv
// Pixel-strobe gated sync history with falling-edge detection for h_sync and v_sync.
// Edge outputs are combinational and only valid on the strobe that produced them.
module vga_sync_sampler (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pix_en,
    input  logic i_h_sync,
    input  logic i_v_sync,
    output logic o_line_start,
    output logic o_vs_fall
);

    logic r_hs_prev;
    logic r_vs_prev;

    // Syncs idle high, so history resets to 1 to avoid a spurious edge out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hs_prev <= 1'b1;
            r_vs_prev <= 1'b1;
        end else if (i_pix_en) begin
            r_hs_prev <= i_h_sync;
            r_vs_prev <= i_v_sync;
        end
    end

    assign o_line_start = i_pix_en && !i_h_sync && r_hs_prev;
    assign o_vs_fall    = i_pix_en && !i_v_sync && r_vs_prev;

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame lengths, locks onto the expected timing and
// emits coordinates and colour of visible pixels once locked.
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_FRAME     = VGA_H_FRAME,
    parameter int unsigned V_FRAME     = VGA_V_FRAME,
    parameter int unsigned H_SYNC      = VGA_H_SYNC,
    parameter int unsigned H_BP        = VGA_H_BP,
    parameter int unsigned H_VIS       = VGA_H_VIS,
    parameter int unsigned V_SYNC      = VGA_V_SYNC,
    parameter int unsigned V_BP        = VGA_V_BP,
    parameter int unsigned V_VIS       = VGA_V_VIS,
    parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES,
    parameter int unsigned CNT_W       = VGA_CNT_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_pix_en,
    input  logic             i_h_sync,
    input  logic             i_v_sync,
    input  logic [3:0]       i_red,
    input  logic [3:0]       i_green,
    input  logic [3:0]       i_blue,
    output logic             o_locked,
    output logic             o_pixel_valid,
    output logic [9:0]       o_pixel_x,
    output logic [9:0]       o_pixel_y,
    output logic [11:0]      o_pixel_rgb,
    output logic             o_frame_start,
    output logic             o_timing_err,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_v_total
);

    localparam int unsigned GOOD_W = $clog2(LOCK_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] H_FRAME_C = CNT_W'(H_FRAME);
    localparam logic [CNT_W-1:0] V_FRAME_C = CNT_W'(V_FRAME);
    localparam logic [CNT_W-1:0] H_VIS_LO  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_VIS_HI  = CNT_W'(H_SYNC + H_BP + H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_LO  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_VIS_HI  = CNT_W'(V_SYNC + V_BP + V_VIS);

    logic w_line_start;
    logic w_vs_fall;

    vga_sync_sampler u_sampler (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_pix_en     (i_pix_en),
        .i_h_sync     (i_h_sync),
        .i_v_sync     (i_v_sync),
        .o_line_start (w_line_start),
        .o_vs_fall    (w_vs_fall)
    );

    logic [CNT_W-1:0]  r_h_cnt, r_v_cnt, r_h_total, r_v_total;
    logic              r_vs_pend, r_line_seen, r_frame_bad, r_discard;
    logic [GOOD_W-1:0] r_good;
    rx_state_e         r_state;
    logic              r_locked, r_pixel_valid, r_frame_start, r_timing_err;
    logic [9:0]        r_pixel_x, r_pixel_y;
    logic [11:0]       r_pixel_rgb;

    logic [CNT_W-1:0] w_h_inc, w_v_inc, w_h_tick, w_v_tick;
    logic             w_frame_evt, w_line_bad, w_frame_bad, w_h_sat, w_visible;

    assign w_h_inc     = (r_h_cnt == CNT_MAX) ? CNT_MAX : r_h_cnt + 1'b1;
    assign w_v_inc     = (r_v_cnt == CNT_MAX) ? CNT_MAX : r_v_cnt + 1'b1;
    assign w_frame_evt = w_line_start && (r_vs_pend || w_vs_fall);
    // The first measured line after SEARCH starts at an arbitrary point, so it is not judged.
    assign w_line_bad  = w_line_start && r_line_seen && (w_h_inc != H_FRAME_C);
    assign w_frame_bad = r_frame_bad || w_line_bad || (w_v_inc != V_FRAME_C);
    assign w_h_sat     = i_pix_en && !w_line_start && (r_h_cnt == CNT_MAX);
    // Counter values belonging to the current tick.
    assign w_h_tick    = w_line_start ? '0 : w_h_inc;
    assign w_v_tick    = w_frame_evt ? '0 : (w_line_start ? w_v_inc : r_v_cnt);
    assign w_visible   = (w_h_tick >= H_VIS_LO) && (w_h_tick < H_VIS_HI) &&
                         (w_v_tick >= V_VIS_LO) && (w_v_tick < V_VIS_HI);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_h_total     <= '0;
            r_v_total     <= '0;
            r_vs_pend     <= 1'b0;
            r_line_seen   <= 1'b0;
            r_frame_bad   <= 1'b0;
            r_discard     <= 1'b0;
            r_good        <= '0;
            r_state       <= SEARCH;
            r_locked      <= 1'b0;
            r_pixel_valid <= 1'b0;
            r_pixel_x     <= '0;
            r_pixel_y     <= '0;
            r_pixel_rgb   <= '0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
        end else begin
            r_pixel_valid <= 1'b0;
            r_frame_start <= 1'b0;
            r_timing_err  <= 1'b0;
            if (i_pix_en) begin
                r_h_cnt <= w_h_tick;
                r_v_cnt <= w_v_tick;
                if (w_line_start) begin
                    r_h_total   <= w_h_inc;
                    r_line_seen <= 1'b1;
                end
                if (w_frame_evt) begin
                    r_v_total     <= w_v_inc;
                    r_vs_pend     <= 1'b0;
                    r_frame_start <= 1'b1;
                end else if (w_vs_fall) begin
                    r_vs_pend <= 1'b1;
                end
                if (r_state == LOCKED && w_visible) begin
                    r_pixel_valid <= 1'b1;
                    r_pixel_x     <= 10'(w_h_tick - H_VIS_LO);
                    r_pixel_y     <= 10'(w_v_tick - V_VIS_LO);
                    r_pixel_rgb   <= {i_red, i_green, i_blue};
                end
                if (w_h_sat) begin
                    r_state     <= SEARCH;
                    r_locked    <= 1'b0;
                    r_good      <= '0;
                    r_line_seen <= 1'b0;
                    r_frame_bad <= 1'b0;
                    r_discard   <= 1'b0;
                end else begin
                    unique case (r_state)
                        SEARCH: begin
                            if (w_frame_evt) begin
                                r_state     <= CHECK;
                                r_good      <= '0;
                                r_frame_bad <= 1'b0;
                                r_discard   <= 1'b0;
                            end
                        end
                        CHECK: begin
                            if (w_frame_evt) begin
                                r_frame_bad <= 1'b0;
                                r_discard   <= 1'b0;
                                if (r_discard) begin
                                    r_good <= '0;
                                end else if (w_frame_bad) begin
                                    r_good       <= '0;
                                    r_timing_err <= 1'b1;
                                end else if (32'(r_good) + 1 == LOCK_FRAMES) begin
                                    r_state  <= LOCKED;
                                    r_locked <= 1'b1;
                                    r_good   <= '0;
                                end else begin
                                    r_good <= r_good + 1'b1;
                                end
                            end else if (w_line_bad) begin
                                r_frame_bad <= 1'b1;
                            end
                        end
                        LOCKED: begin
                            if (w_line_bad || (w_frame_evt && w_frame_bad)) begin
                                r_state      <= CHECK;
                                r_locked     <= 1'b0;
                                r_good       <= '0;
                                r_timing_err <= 1'b1;
                                r_frame_bad  <= 1'b0;
                                // A mid-frame loss leaves a torn frame that must not be judged.
                                r_discard    <= !w_frame_evt;
                            end
                        end
                        default: begin
                            r_state  <= SEARCH;
                            r_locked <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign o_locked      = r_locked;
    assign o_pixel_valid = r_pixel_valid;
    assign o_pixel_x     = r_pixel_x;
    assign o_pixel_y     = r_pixel_y;
    assign o_pixel_rgb   = r_pixel_rgb;
    assign o_frame_start = r_frame_start;
    assign o_timing_err  = r_timing_err;
    assign o_h_total     = r_h_total;
    assign o_v_total     = r_v_total;

endmodule

// File: tb/tb_vga_timing_rx.sv
// Directed bench for vga_timing_rx using a scaled-down raster so whole frames stay short.
module tb_vga_timing_rx;

    localparam int HS = 4, HB = 3, HV = 8, HF = 2, HT = HS + HB + HV + HF;  // 17
    localparam int VS = 2, VB = 2, VV = 4, VF = 1, VT = VS + VB + VV + VF;  // 9
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, pix_en, h_sync, v_sync;
    logic [3:0]    red, green, blue;
    logic          locked, pixel_valid, frame_start, timing_err;
    logic [9:0]    pixel_x, pixel_y;
    logic [11:0]   pixel_rgb;
    logic [CW-1:0] h_total, v_total;

    vga_timing_rx #(
        .H_FRAME(HT), .V_FRAME(VT), .H_SYNC(HS), .H_BP(HB), .H_VIS(HV),
        .V_SYNC(VS), .V_BP(VB), .V_VIS(VV), .LOCK_FRAMES(2), .CNT_W(CW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_pix_en(pix_en), .i_h_sync(h_sync), .i_v_sync(v_sync),
        .i_red(red), .i_green(green), .i_blue(blue),
        .o_locked(locked), .o_pixel_valid(pixel_valid), .o_pixel_x(pixel_x),
        .o_pixel_y(pixel_y), .o_pixel_rgb(pixel_rgb), .o_frame_start(frame_start),
        .o_timing_err(timing_err), .o_h_total(h_total), .o_v_total(v_total)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    int fs_cnt = 0, err_cnt = 0, rise_fs = -1, fall_with_err = 0, wide_pulse = 0;
    int pix_total = 0, pix_cnt = 0, frame_pix = 0, rgb_bad = 0;
    int first_x = -1, first_y = -1, last_x = -1, last_y = -1;
    bit want_first = 0, locked_prev = 0, pv_prev = 0;

    always @(negedge clk) begin
        if (frame_start) begin
            fs_cnt++;
            frame_pix = pix_cnt;
            pix_cnt = 0;
            want_first = 1;
        end
        if (timing_err) err_cnt++;
        if (locked && !locked_prev) rise_fs = fs_cnt;
        if (!locked && locked_prev && timing_err) fall_with_err++;
        if (pixel_valid) begin
            pix_total++;
            pix_cnt++;
            if (want_first) begin
                first_x = int'(pixel_x);
                first_y = int'(pixel_y);
                want_first = 0;
            end
            last_x = int'(pixel_x);
            last_y = int'(pixel_y);
            if (pixel_rgb != 12'hA5C) rgb_bad++;
        end
        if (pixel_valid && pv_prev) wide_pulse++;
        locked_prev = locked;
        pv_prev = pixel_valid;
    end

    // Raster generator: gx/gy is the position of the next tick, divider 3.
    int gx = 0, gy = 0, drop_y = -1;
    bit stuck = 0;

    task automatic tick();
        @(negedge clk);
        pix_en = 1'b1;
        h_sync = (stuck || gy == drop_y) ? 1'b1 : (gx < HS ? 1'b0 : 1'b1);
        v_sync = (gy < VS) ? 1'b0 : 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        gx++;
        if (gx == HT) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end
    endtask

    task automatic run_until(input int x, input int y);
        while (!(gx == x && gy == y)) tick();
        tick();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_pv"}, int'(pixel_valid), 0);
        check({tag, "_fs"}, int'(frame_start), 0);
        check({tag, "_err"}, int'(timing_err), 0);
        check({tag, "_htot"}, int'(h_total), 0);
        check({tag, "_vtot"}, int'(v_total), 0);
        check({tag, "_px"}, int'(pixel_x), 0);
        check({tag, "_py"}, int'(pixel_y), 0);
        check({tag, "_rgb"}, int'(pixel_rgb), 0);
    endtask

    int base, pix_base;

    initial begin
        rst = 1'b1; pix_en = 1'b0; h_sync = 1'b1; v_sync = 1'b1;
        {red, green, blue} = 12'hA5C;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Nominal: five frame starts over four whole frames.
        repeat (4 * VT * HT) tick();
        tick();
        check("nom_htot", int'(h_total), HT);
        check("nom_vtot", int'(v_total), VT);
        check("nom_locked", int'(locked), 1);
        check("nom_fs_cnt", fs_cnt, 5);
        check("nom_lock_at_fs", rise_fs, 3);
        check("nom_err", err_cnt, 0);

        // Pixels of the two locked frames.
        check("pix_per_frame", frame_pix, HV * VV);
        check("pix_total", pix_total, 2 * HV * VV);
        check("pix_first_x", first_x, 0);
        check("pix_first_y", first_y, 0);
        check("pix_last_x", last_x, HV - 1);
        check("pix_last_y", last_y, VV - 1);
        check("pix_x_hold", int'(pixel_x), HV - 1);
        check("pix_rgb_bad", rgb_bad, 0);
        check("pix_width", wide_pulse, 0);

        // Drop the h_sync pulse of line 5 while locked.
        drop_y = 5;
        run_until(0, 6);
        drop_y = -1;
        check("drop_htot", int'(h_total), 2 * HT);
        check("drop_err", err_cnt, 1);
        check("drop_locked", int'(locked), 0);
        check("drop_fall_err", fall_with_err, 1);
        run_until(0, 0);
        check("drop_vtot", int'(v_total), VT - 1);
        check("drop_discard_err", err_cnt, 1);
        run_until(0, 0);
        check("drop_locked_g1", int'(locked), 0);
        run_until(0, 0);
        check("drop_relock", int'(locked), 1);
        check("drop_err_final", err_cnt, 1);

        // h_sync stuck high long enough to saturate the line counter.
        stuck = 1;
        pix_base = pix_total;
        repeat (300) tick();
        check("sat_locked", int'(locked), 0);
        check("sat_no_pix", pix_total - pix_base, 0);
        check("sat_pv", int'(pixel_valid), 0);
        while (gx != 0) tick();
        stuck = 0;
        tick();
        check("sat_htot", int'(h_total), 255);
        check("sat_locked_after", int'(locked), 0);

        // Reset mid-frame while locked.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        gx = 0; gy = 0;
        tick();
        run_until(0, 0);
        run_until(0, 0);
        check("mid_pre_locked", int'(locked), 1);
        run_until(3, 6);
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        base = fs_cnt;
        run_until(0, 0);
        check("mid_fs1_locked", int'(locked), 0);
        run_until(0, 0);
        check("mid_fs2_locked", int'(locked), 0);
        run_until(0, 0);
        check("mid_fs3_locked", int'(locked), 1);
        check("mid_lock_at_fs", rise_fs - base, 3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
